// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction-fetch stage.
//   fetch_state_t : fetch FSM states (IDLE, REQ, WAIT)
//   fetch_entry_t : one buffered fetch result {pc, instr, misalign}
//   INSTR_BYTES   : PC increment per sequential fetch
//   NOP_INSTR     : instruction substituted for a misaligned fetch
// fetch_entry_t is sized by PKG_XLEN; fetch_unit's XLEN must equal it.
package fetch_pkg;

    localparam int          PKG_XLEN    = 32;
    localparam int          INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [PKG_XLEN-1:0] pc;
        logic [31:0]         instr;
        logic                misalign;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// fetch_buffer: synchronous FIFO of fetch_entry_t between memory and decode.
// Ports:
//   clk, reset       clock, asynchronous active-low reset
//   push_i/push_data_i  write one entry (accepted when not full or popping)
//   pop_i            remove the head entry (ignored when empty)
//   flush_i          discard all entries; wins over push/pop
//   head_o           head entry, forced to zero while empty
//   count_o          number of stored entries
//   full_o, empty_o  occupancy flags
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  fetch_entry_t           push_data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output fetch_entry_t           head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push;
    logic         do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign empty_o = (count_o == '0);
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Zero while empty so decode never sees stale data after a flush or reset.
    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: contents are only visible through head_o when non-empty.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage between the PC register and decode.
// Issues one instruction-memory request at a time, buffers responses in
// fetch_buffer and presents {pc, instr} to decode with valid/ready.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   pc / next_pc / pc_en        PC register interface (pc_en is combinational)
//   redirect_valid/redirect_pc  taken branch/jump: reload PC, flush, drop in-flight
//   imem_req_*/imem_addr        request channel (address = pc)
//   imem_rsp_valid/_data        one response per accepted request
//   if_valid/if_ready/if_pc/if_instr   decode channel
//   if_misalign                 only with FETCH_MISALIGN_CHECK_EN defined
//   dbg_state                   current FSM state
// Handshakes: a transfer happens on a cycle where valid && ready; once
// imem_req_valid is raised it and imem_addr hold until accepted unless a
// redirect cancels the request.
// Macro FETCH_MISALIGN_CHECK_EN: a pc with pc[1:0] != 0 issues no memory
// request; a NOP entry flagged misaligned is pushed instead.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int XLEN      = PKG_XLEN,
    parameter int BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] next_pc,
    output logic            pc_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
`ifdef FETCH_MISALIGN_CHECK_EN
    output logic            if_misalign,
`endif
    output fetch_state_t    dbg_state
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;

    fetch_state_t    state_q, state_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] tag_q, tag_d;

    logic            push, pop, flush;
    fetch_entry_t    push_entry, head;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full, fifo_empty;
    logic            rsp_in, rsp_keep, issue_ok;
    logic [CW:0]     load_after;
    logic [XLEN-1:0] pc_plus4;

    assign pc_plus4  = pc + XLEN'(INSTR_BYTES);
    assign if_valid  = !fifo_empty;
    assign pop       = if_valid && if_ready;
    assign if_pc     = head.pc;
    assign if_instr  = head.instr;
    assign imem_addr = (state_q != IDLE) ? pc : '0;
    assign dbg_state = state_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign if_misalign = head.misalign;
`endif

    always_comb begin
        state_d        = state_q;
        drop_d         = drop_q;
        tag_d          = tag_q;
        imem_req_valid = 1'b0;
        pc_en          = 1'b0;
        next_pc        = '0;
        push           = 1'b0;
        push_entry     = '0;
        flush          = 1'b0;
        issue_ok       = 1'b0;
        rsp_in         = (state_q == WAIT) && imem_rsp_valid;
        rsp_keep       = rsp_in && !drop_q;
        // Entries the buffer will hold after this edge; a new request is only
        // issued if its response is guaranteed a slot.
        load_after     = {1'b0, fifo_count} + (CW+1)'(rsp_keep) - (CW+1)'(pop);

        case (state_q)
            IDLE: state_d = REQ;
            REQ:  issue_ok = 1'b1;
            WAIT: begin
                if (rsp_in) begin
                    drop_d   = 1'b0;
                    state_d  = REQ;
                    issue_ok = 1'b1;  // back-to-back request on the response cycle
                    if (rsp_keep) begin
                        push             = 1'b1;
                        push_entry.pc    = tag_q;
                        push_entry.instr = imem_rsp_data;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue_ok && (load_after < (CW+1)'(BUF_DEPTH))) begin
`ifdef FETCH_MISALIGN_CHECK_EN
            if (pc[1:0] != 2'b00) begin
                // Only from REQ, so it never collides with a response push.
                if (state_q == REQ) begin
                    push                = 1'b1;
                    push_entry.pc       = pc;
                    push_entry.instr    = NOP_INSTR;
                    push_entry.misalign = 1'b1;
                    pc_en               = 1'b1;
                    next_pc             = pc_plus4;
                end
            end else
`endif
            begin
                imem_req_valid = 1'b1;
                if (imem_req_ready) begin
                    pc_en   = 1'b1;
                    next_pc = pc_plus4;
                    tag_d   = pc;
                    state_d = WAIT;
                end
            end
        end

        // Redirect overrides everything decided above.
        if (redirect_valid && (state_q != IDLE)) begin
            flush          = 1'b1;
            push           = 1'b0;
            imem_req_valid = 1'b0;
            pc_en          = 1'b1;
            next_pc        = redirect_pc;
            tag_d          = tag_q;
            if ((state_q == WAIT) && !imem_rsp_valid) begin
                // Response still in flight: stay in WAIT and discard it on arrival.
                state_d = WAIT;
                drop_d  = 1'b1;
            end else begin
                state_d = REQ;
                drop_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
            tag_q   <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            tag_q   <= tag_d;
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk         (clk),
        .reset       (reset),
        // Never overwrite a full buffer, even if the credit logic were bypassed.
        .push_i      (push && (!fifo_full || pop)),
        .push_data_i (push_entry),
        .pop_i       (pop),
        .flush_i     (flush),
        .head_o      (head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam int          XLEN  = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    // ---------------- clock / reset / DUT ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                   reset;
    logic [XLEN-1:0]        pc, next_pc, redirect_pc, imem_addr, if_pc;
    logic                   pc_en, redirect_valid, imem_req_valid, imem_req_ready;
    logic                   imem_rsp_valid, if_valid, if_ready;
    logic [31:0]            imem_rsp_data, if_instr;
    fetch_pkg::fetch_state_t dbg_state;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic                   if_misalign;
`endif

    fetch_unit #(.XLEN(XLEN), .BUF_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc             (pc),
        .next_pc        (next_pc),
        .pc_en          (pc_en),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
`ifdef FETCH_MISALIGN_CHECK_EN
        .if_misalign    (if_misalign),
`endif
        .dbg_state      (dbg_state)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_f(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] a);
        logic [31:0] r;
        r = mem_f(a);
`ifdef FETCH_MISALIGN_CHECK_EN
        if (a[1:0] != 2'b00) r = NOP;
`endif
        return r;
    endfunction

    // Program-order model: decode must see consecutive addresses starting at
    // the reset PC or the latest redirect target.
    logic [31:0] exp_pc;
    logic [31:0] exp_q[$];     // PCs accepted by decode, in order
    logic [31:0] acc_q[$];     // addresses accepted by memory, in order
    int          n_pops = 0;
    bit          m_pc_en, m_req_acc;
    logic [31:0] m_next_pc, m_req_addr;
    bit          prev_stall, flush_chk, wrap_seen;
    logic [31:0] prev_addr, wrap_next;

    // Memory slot owned by the driver.
    bit          busy;
    logic [31:0] slot_addr;
    int          slot_wait;

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [31:0] diff;
        if (!reset) begin
            chk("rst_ctrl", {29'b0, imem_req_valid, pc_en, if_valid}, 32'h0);
            chk("rst_next_pc", next_pc, 32'h0);
            chk("rst_imem_addr", imem_addr, 32'h0);
            chk("rst_if_pc", if_pc, 32'h0);
            chk("rst_if_instr", if_instr, 32'h0);
            chk("rst_state", 32'(dbg_state), 32'(fetch_pkg::IDLE));
            exp_pc     = pc;
            m_pc_en    = 1'b0;
            m_req_acc  = 1'b0;
            prev_stall = 1'b0;
            flush_chk  = 1'b0;
        end else begin
            if (flush_chk) chk("flush_if_valid", {31'b0, if_valid}, 32'h0);
            flush_chk = 1'b0;

            // Fetched-but-not-decoded work never exceeds the buffer size.
            diff = pc - exp_pc;
            chk("inflight_bound", {31'b0, (diff <= 32'(4*DEPTH)) && (diff[1:0] == 2'b00)}, 32'h1);

            if (prev_stall && !redirect_valid) begin
                chk("req_hold_valid", {31'b0, imem_req_valid}, 32'h1);
                chk("req_hold_addr", imem_addr, prev_addr);
            end

            if (if_valid && if_ready) begin
                chk("if_pc", if_pc, exp_pc);
                chk("if_instr", if_instr, exp_instr(exp_pc));
`ifdef FETCH_MISALIGN_CHECK_EN
                chk("if_misalign", {31'b0, if_misalign}, {31'b0, exp_pc[1:0] != 2'b00});
`endif
                exp_q.push_back(if_pc);
                n_pops++;
                exp_pc = exp_pc + 32'd4;
            end

            if (redirect_valid) begin
                chk("redir_pc_en", {31'b0, pc_en}, 32'h1);
                chk("redir_next_pc", next_pc, redirect_pc);
                chk("redir_req_valid", {31'b0, imem_req_valid}, 32'h0);
                exp_pc    = redirect_pc;
                flush_chk = 1'b1;
            end else if (imem_req_valid && imem_req_ready) begin
                chk("acc_pc_en", {31'b0, pc_en}, 32'h1);
                chk("acc_next_pc", next_pc, pc + 32'd4);
                chk("acc_addr", imem_addr, pc);
                chk("one_outstanding", {31'b0, busy && !imem_rsp_valid}, 32'h0);
                acc_q.push_back(imem_addr);
                if (pc == 32'hFFFF_FFFC) begin
                    wrap_seen = 1'b1;
                    wrap_next = next_pc;
                end
`ifdef FETCH_MISALIGN_CHECK_EN
            end else if (pc[1:0] != 2'b00 && pc_en) begin
                chk("mis_next_pc", next_pc, pc + 32'd4);
                chk("mis_no_req", {31'b0, imem_req_valid}, 32'h0);
`endif
            end else begin
                chk("pc_en_idle", {31'b0, pc_en}, 32'h0);
            end

            m_pc_en    = pc_en;
            m_next_pc  = next_pc;
            m_req_acc  = imem_req_valid && imem_req_ready && !redirect_valid;
            m_req_addr = imem_addr;
            prev_stall = imem_req_valid && !imem_req_ready && !redirect_valid;
            prev_addr  = imem_addr;
        end
    end

    // ---------------- driver ----------------
    int lat_min = 1, lat_max = 1, rdy_pct = 100, ifr_pct = 100;

    // One clock: acts as PC register and instruction memory, then draws new inputs.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (m_pc_en) pc = m_next_pc;
        if (imem_rsp_valid) busy = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = $urandom();
        if (m_req_acc) begin
            busy      = 1'b1;
            slot_addr = m_req_addr;
            slot_wait = $urandom_range(lat_max, lat_min) - 1;
        end else if (busy && slot_wait > 0) begin
            slot_wait--;
        end
        if (busy && slot_wait == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_f(slot_addr);
        end
        imem_req_ready = ($urandom_range(99, 0) < rdy_pct);
        if_ready       = ($urandom_range(99, 0) < ifr_pct);
        redirect_valid = 1'b0;
    endtask

    task automatic wait_accept(input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            cycle();
            if (m_req_acc) found = 1'b1;
        end
        chk(name, {31'b0, found}, 32'h1);
    endtask

    task automatic redirect(input logic [31:0] target);
        redirect_valid = 1'b1;
        redirect_pc    = target;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, p0, n0;
        reset = 1'b0; pc = '0; redirect_valid = 1'b0; redirect_pc = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
        if_ready = 1'b0; busy = 1'b0; slot_wait = 0; wrap_seen = 1'b0; wrap_next = '1;
        repeat (3) cycle();
        reset = 1'b1;

        // Sequential stream from 0, 1-cycle memory, decode always ready.
        repeat (10) cycle();
        n0 = n_pops;
        repeat (20) cycle();
        chk("throughput_20", n_pops - n0, 20);
        chk("first_req_0", acc_q[0], 32'h0);
        chk("first_req_1", acc_q[1], 32'h4);
        chk("first_req_2", acc_q[2], 32'h8);
        chk("first_pop_0", exp_q[0], 32'h0);
        chk("first_pop_2", exp_q[2], 32'h8);

        // Decode stalls: buffer fills to DEPTH and fetch stops.
        ifr_pct = 0;
        repeat (12) cycle();
        #1;
        chk("full_req_valid", {31'b0, imem_req_valid}, 32'h0);
        chk("full_pc_en", {31'b0, pc_en}, 32'h0);
        chk("full_if_valid", {31'b0, if_valid}, 32'h1);
        chk("full_depth", pc - exp_pc, 32'(4*DEPTH));
        ifr_pct = 100;
        n0 = n_pops;
        repeat (11) cycle();
        chk("resume_pops", n_pops - n0, 10);

        // Redirect while a 3-cycle response is in flight.
        lat_min = 3; lat_max = 3;
        wait_accept("wait_acc_redirect");
        redirect(32'hDEADCAFC);
        a0 = acc_q.size();
        #1;
        chk("redir_lit_next_pc", next_pc, 32'hDEADCAFC);
        chk("redir_lit_pc_en", {31'b0, pc_en}, 32'h1);
        cycle();
        p0 = exp_q.size();
        repeat (15) cycle();
        chk("redir_next_req", (acc_q.size() > a0) ? acc_q[a0] : 32'hFFFF_FFFF, 32'hDEADCAFC);
        chk("redir_next_pop", (exp_q.size() > p0) ? exp_q[p0] : 32'hFFFF_FFFF, 32'hDEADCAFC);

        // Address wrap at the top of memory.
        lat_min = 1; lat_max = 1;
        cycle();
        redirect(32'hFFFF_FFF0);
        repeat (15) cycle();
        chk("wrap_seen", {31'b0, wrap_seen}, 32'h1);
        chk("wrap_next_pc", wrap_next, 32'h0);

        // Reset while in WAIT with the response due on the next cycle.
        lat_min = 2; lat_max = 2;
        wait_accept("wait_acc_reset");
        reset = 1'b0;
        repeat (3) cycle();
        pc = 32'h0000_0100;
        cycle();
        reset = 1'b1;
        a0 = acc_q.size();
        p0 = exp_q.size();
        repeat (10) cycle();
        chk("post_rst_req", (acc_q.size() > a0) ? acc_q[a0] : 32'hFFFF_FFFF, 32'h100);
        chk("post_rst_pop", (exp_q.size() > p0) ? exp_q[p0] : 32'hFFFF_FFFF, 32'h100);

`ifdef FETCH_MISALIGN_CHECK_EN
        // Misaligned target: NOP entries, no memory traffic.
        lat_min = 1; lat_max = 1;
        redirect(32'hDEADCAFE);
        cycle();
        #1;
        chk("mis_lit_req", {31'b0, imem_req_valid}, 32'h0);
        chk("mis_lit_pc_en", {31'b0, pc_en}, 32'h1);
        chk("mis_lit_next_pc", next_pc, 32'hDEADCB02);
        a0 = acc_q.size();
        p0 = exp_q.size();
        repeat (8) cycle();
        chk("mis_no_traffic", acc_q.size() - a0, 0);
        chk("mis_first_pop", (exp_q.size() > p0) ? exp_q[p0] : 32'hFFFF_FFFF, 32'hDEADCAFE);
        redirect(32'h0000_2000);
        repeat (4) cycle();
`endif

        // Randomised traffic: stalls on both sides, variable latency, redirects.
        lat_min = 1; lat_max = 3; rdy_pct = 70; ifr_pct = 60;
        n0 = n_pops;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if ($urandom_range(99, 0) < 3) redirect($urandom() & 32'hFFFF_FFFC);
        end
        chk("random_progress", {31'b0, (n_pops - n0) > 200}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
